// File: rtl/clk_prescale_ctrl.sv
// clk_prescale_ctrl -- run-time controller for the BDC main-clock prescaler.
//
// clk_out = clk / (2*(active_half+1)). The default ratio of 9 turns
// 49.152 MHz into 2.4576 MHz. A new ratio comes in on the cfg valid/ready
// port. While the divider runs, the new ratio waits in a pending slot and
// takes effect only at the falling toggle, so clk_out never glitches.
// Stopping always leaves clk_out parked low.
//
// Optional build macro: PRESCALE_EDGE_CNT_EN adds a 16-bit rising-edge
// counter (edge_cnt) and a synchronous clear input (edge_cnt_clr).
//
// Ports:
//   clk, reset     system clock; asynchronous active-high reset
//   en             level run request (1 = run, 0 = stop)
//   cfg_valid      config request
//   cfg_half       requested terminal count (half period = cfg_half+1 clks)
//   cfg_ready      config slot free
//   cfg_err        1-cycle pulse: accepted request below MIN_HALF dropped
//   clk_out        divided clock, registered
//   rise_stb       1-cycle pulse with clk_out 0->1
//   fall_stb       1-cycle pulse with clk_out 1->0
//   running        controller not idle
//   busy           update pending (~cfg_ready)
//   edge_cnt_clr   (optional) synchronous clear of edge_cnt
//   edge_cnt       (optional) rise_stb count, wraps at 16 bits
module clk_prescale_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 9,
  parameter int MIN_HALF = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PRESCALE_EDGE_CNT_EN
  input  logic             edge_cnt_clr,
  output logic [15:0]      edge_cnt,
`endif
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HALF);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] pend_half;
  logic             pend;

  logic acc, acc_ok, acc_bad, term, fall, trunc, go_idle;

  always_comb begin
    acc     = cfg_valid && !pend;
    acc_ok  = acc && (cfg_half >= MIN_H);
    acc_bad = acc && (cfg_half < MIN_H);
    term    = (cnt == active_half);
    fall    = (state != IDLE) && term && clk_out;
    // Stop request during the low phase: cut the phase short, go idle.
    trunc   = (state == RUN) && !en && !clk_out;
    go_idle = (state != IDLE) && (trunc || (fall && !en));
  end

  assign cfg_ready = !pend;
  assign busy      = pend;
  assign running   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      clk_out     <= 1'b0;
      active_half <= DEF_H;
      pend_half   <= '0;
      pend        <= 1'b0;
      cfg_err     <= 1'b0;
      rise_stb    <= 1'b0;
      fall_stb    <= 1'b0;
    end else begin
      cfg_err  <= acc_bad;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;

      // Idle: the ratio can be loaded immediately. Otherwise park it.
      if (acc_ok) begin
        if (state == IDLE) active_half <= cfg_half;
        else begin
          pend_half <= cfg_half;
          pend      <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          // Leftover from a request accepted on the edge that entered IDLE.
          if (pend) begin
            active_half <= pend_half;
            pend        <= 1'b0;
          end
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          if (trunc) begin
            state <= IDLE;
            cnt   <= '0;
            if (pend) begin
              active_half <= pend_half;
              pend        <= 1'b0;
            end else if (acc_ok) begin
              active_half <= cfg_half;
              pend        <= 1'b0;
            end
          end else begin
            if (term) begin
              cnt      <= '0;
              clk_out  <= !clk_out;
              rise_stb <= !clk_out;
              fall_stb <= clk_out;
              // New ratio starts with the low phase after the fall.
              if (clk_out && pend) begin
                active_half <= pend_half;
                pend        <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
            // A fall always finishes a stop. A rising en during STOP only
            // takes effect here, after the fall.
            if (fall)                        state <= en ? RUN : IDLE;
            else if ((state == RUN) && !en)  state <= STOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRESCALE_EDGE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             edge_cnt <= '0;
    else if (edge_cnt_clr) edge_cnt <= '0;
    else if (go_idle)      edge_cnt <= '0;
    else if (rise_stb)     edge_cnt <= edge_cnt + 16'd1;
  end
`else
  logic unused_go_idle;
  assign unused_go_idle = go_idle;
`endif

endmodule

// File: tb/tb_clk_prescale_ctrl.sv
// Bench for clk_prescale_ctrl. Each stimulus phase pushes the expected
// clk_out edges (kind + clk cycle) to a queue. A negedge monitor pops one
// entry per strobe and compares it. Level checks go through chk directly.
module tb_clk_prescale_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready, cfg_err, clk_out, rise_stb, fall_stb, running, busy;

  clk_prescale_ctrl #(.CNT_W(8), .DEF_HALF(9), .MIN_HALF(1)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid),
    .cfg_half(cfg_half), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .running(running), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rise; int cyc; } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit r, input int c);
    ev_t e;
    e.rise = r;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Returns just after the edge that brings cyc to n. Inputs driven after
  // this take effect at edge n+1.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rise_stb || fall_stb)) begin
      if (exp_q.size() == 0) chk("unexp_edge", exp_q.size(), 1);
      else begin
        mon_e = exp_q.pop_front();
        chk(mon_e.rise ? "rise_cyc" : "fall_cyc", cyc, mon_e.cyc);
        chk("edge_kind", rise_stb, mon_e.rise);
        chk("edge_lvl", clk_out, mon_e.rise);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_running", running, 0);
    chk("rst_rise", rise_stb, 0);
    chk("rst_fall", fall_stb, 0);

    // Default ratio, then a stop request 3 cycles into the high phase.
    t = cyc;
    reset = 1'b0; en = 1'b1;
    push(1, t+11); push(0, t+21);
    wait_cyc(t+5);  chk("run_running", running, 1);
    wait_cyc(t+13); en = 1'b0;
    wait_cyc(t+21); chk("stop_running", running, 0);
    wait_cyc(t+25); chk("stop_park", clk_out, 0);

    // Ratio 4 loaded while idle, then en toggles low and high during STOP.
    chk("idle_ready_pre", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_half = 8'd4;
    wait_cyc(t+26);
    cfg_valid = 1'b0;
    chk("idle_ready_post", cfg_ready, 1);
    chk("idle_busy", busy, 0);
    wait_cyc(t+27); en = 1'b1;
    push(1, t+33); push(0, t+38); push(1, t+43); push(0, t+48);
    push(1, t+53); push(0, t+58);
    wait_cyc(t+44); en = 1'b0;
    wait_cyc(t+46); en = 1'b1; chk("stop_running_mid", running, 1);

    // Ratio 9 accepted mid-high phase, applied at the fall.
    wait_cyc(t+54); cfg_valid = 1'b1; cfg_half = 8'd9;
    wait_cyc(t+55); cfg_valid = 1'b0;
    chk("pend_busy", busy, 1);
    chk("pend_ready", cfg_ready, 0);
    push(1, t+68); push(0, t+78);
    wait_cyc(t+58); chk("apply_busy", busy, 0);

    // Ratio 2 mid-high at half 9. A second request while busy is ignored.
    wait_cyc(t+70); cfg_valid = 1'b1; cfg_half = 8'd2;
    wait_cyc(t+71); chk("pend2_busy", busy, 1); cfg_half = 8'd7;
    wait_cyc(t+72); cfg_valid = 1'b0;
    wait_cyc(t+77); chk("pend2_busy_hold", busy, 1);
    push(1, t+81); push(0, t+84); push(1, t+87); push(0, t+90);
    push(1, t+93); push(0, t+96); push(1, t+99);
    wait_cyc(t+78); chk("apply2_busy", busy, 0);

    // cfg_half below MIN_HALF: one-cycle error, ratio unchanged.
    wait_cyc(t+91); cfg_valid = 1'b1; cfg_half = 8'd0;
    wait_cyc(t+92); cfg_valid = 1'b0;
    chk("err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    wait_cyc(t+93); chk("err_clear", cfg_err, 0);

    // Reset while clk_out is high and an update is pending.
    wait_cyc(t+99); cfg_valid = 1'b1; cfg_half = 8'd5;
    wait_cyc(t+100); cfg_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_clk", clk_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_clk_out", clk_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_running", running, 0);
    wait_cyc(t+103); reset = 1'b0;
    // Only the default ratio gives these times: the pending 5 is lost.
    push(1, t+114); push(0, t+124);
    wait_cyc(t+126); en = 1'b0;
    wait_cyc(t+127);
    chk("trunc_running", running, 0);
    chk("trunc_clk", clk_out, 0);

    // en drop and config accept on the same edge: both take effect.
    wait_cyc(t+140); en = 1'b1;
    push(1, t+151); push(0, t+161);
    wait_cyc(t+162); en = 1'b0; cfg_valid = 1'b1; cfg_half = 8'd3;
    wait_cyc(t+163); cfg_valid = 1'b0;
    chk("both_running", running, 0);
    chk("both_ready", cfg_ready, 1);
    wait_cyc(t+165); en = 1'b1;
    push(1, t+170); push(0, t+174);
    wait_cyc(t+175); en = 1'b0;
    wait_cyc(t+185);
    chk("final_running", running, 0);
    chk("q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_prescale_ctrl.md
Name: clk_prescale_ctrl

Overview:
Run-time controller for the BDC main-clock prescaler. It generates clk_out from clk by divide-by-2*(half+1) counting; half = 9 gives 49.152 MHz -> 2.4576 MHz. The divide ratio is loaded through a valid/ready config port and changes only at a period boundary, so clk_out never glitches. A start/stop sequence ensures clk_out always parks low.

Parameters:
CNT_W, 8, width of half-period counter and ratio registers
DEF_HALF, 9, active half-period terminal count after reset
MIN_HALF, 1, smallest accepted cfg_half; smaller values are rejected

Ports:
clk  input  1  system clock (49.152 MHz)
reset  input  1  asynchronous, active-high
en  input  1  level run request; 1 = run, 0 = stop
cfg_valid  input  1  config request
cfg_half  input  CNT_W  requested terminal count; half period = cfg_half+1 clk cycles
cfg_ready  output  1  config slot free
cfg_err  output  1  one-cycle pulse: accepted request with cfg_half < MIN_HALF was discarded
clk_out  output  1  divided clock, registered
rise_stb  output  1  one-cycle pulse on the edge where clk_out goes 0->1
fall_stb  output  1  one-cycle pulse on the edge where clk_out goes 1->0
running  output  1  state != IDLE
busy  output  1  update pending (equals ~cfg_ready)

Behaviour:
- Clock and reset: reset is asynchronous, active-high; the block is clocked on clk.
- Reset values: state = IDLE; cnt = 0; clk_out = 0; active_half = DEF_HALF; pending flag = 0; cfg_ready = 1; busy = 0; cfg_err = 0; rise_stb = 0; fall_stb = 0; running = 0.
- Counting in RUN and STOP, every clk edge:
  - If cnt == active_half: cnt <= 0, clk_out <= ~clk_out, and the matching strobe fires on that edge.
  - Otherwise: cnt <= cnt+1.
  - cnt never exceeds active_half.
- State IDLE:
  - clk_out = 0, cnt = 0.
  - en = 1 -> RUN on the next edge, with cnt = 0.
  - The first rise occurs active_half+1 cycles after entering RUN.
- State RUN:
  - en = 0 with clk_out = 0 -> IDLE next edge. The low phase is truncated; cnt clears.
  - en = 0 with clk_out = 1 -> STOP.
- State STOP:
  - Counting continues; the falling toggle completes normally.
  - On the fall edge: if en = 1, go to RUN with cnt = 0; otherwise go to IDLE.
  - en re-asserting during STOP does not abort the fall.
- Config handshake:
  - A request is accepted when cfg_valid && cfg_ready.
  - cfg_half < MIN_HALF: cfg_err pulses on the next cycle; no state changes.
  - Accepted in IDLE: active_half loads on the next edge; cfg_ready stays 1.
  - Accepted in RUN or STOP: the value is stored in pending_half, the pending flag is set, and cfg_ready drops.
- Applying a pending update:
  - It applies on the fall-toggle edge (clk_out 1->0 while cnt == active_half), so the following low phase uses the new ratio.
  - It also applies on the RUN->IDLE transition taken with clk_out = 0.
  - On apply: active_half <= pending_half, the pending flag clears, and cfg_ready returns to 1 on the next cycle.
- Simultaneous events:
  - Fall edge and a new cfg_valid in the same cycle: the request is not accepted that cycle (cfg_ready is still 0).
  - en drop and config accept in the same cycle: both take effect.
- Periods: clk_out high and low phases are each exactly active_half+1 cycles, except the truncated low phase on stop.
- Reset mid-operation: clk_out drops immediately (asynchronous); any pending update is lost.

Optional Feature:
PRESCALE_EDGE_CNT_EN
- Defined:
  - Adds output edge_cnt [15:0], incremented on every rise_stb and wrapping 0xFFFF -> 0.
  - Cleared by reset and on IDLE entry.
  - Adds input edge_cnt_clr, a synchronous clear that takes priority over increment.
- Undefined: no ports and no logic are added.

Test Plan:
- Reset release, en = 1 at cycle 0, default ratio -> first rise_stb 10 cycles after RUN entry; clk_out period 20 cycles (2.4576 MHz at 49.152 MHz).
- In IDLE, cfg_half = 4 accepted -> next start gives period 10; cfg_ready stays 1.
- Running at half = 9, cfg_half = 2 accepted mid-high-phase -> busy = 1 until the fall edge; then low phase 3 cycles, period 6 thereafter; no phase shorter than 3 cycles.
- cfg_half = 0 with MIN_HALF = 1 -> cfg_err pulses 1 cycle; period unchanged at 20.
- en drops 3 cycles into the high phase -> STOP; fall_stb after the remaining 7 cycles; running = 0 next edge; clk_out stays 0.
- Assert reset while clk_out = 1 and an update is pending -> clk_out = 0, busy = 0, active_half = 9 immediately.
